ika3012_serialrx: RTL

//  DAC-side receiver for the OPM serial audio link: SO data framed by SH1/SH2 strobes, bit-clocked on phi1.

---
 rtl/ika3012_serialrx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ika3012_serialrx.sv
// DAC-side receiver for the OPM serial audio link: deserialises SO, latches one
// floating-point sample per channel on SH1/SH2 falls, converts to linear PCM, tracks frame lock.
module ika3012_serialrx #(
  parameter int FRAME_LEN  = 32,
  parameter int LOCK_COUNT = 2,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_RST,
  input  logic                 i_phi1_NCEN_n,
  input  logic                 i_SO,
  input  logic                 i_SH1,
  input  logic                 i_SH2,
  output logic [OUT_WIDTH-1:0] o_CH1,
  output logic [OUT_WIDTH-1:0] o_CH2,
  output logic                 o_CH1_VALID,
  output logic                 o_CH2_VALID,
  output logic                 o_LOCKED,
  output logic                 o_FRAME_ERR
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [5:0] PERIOD    = 6'(FRAME_LEN);
  localparam logic [5:0] CNT_MAX   = 6'd63;
  localparam logic [7:0] GOOD_MAX  = 8'(LOCK_COUNT);

  logic [15:0]          sr_q, sr_d;
  logic                 sh1_q, sh1_d, sh2_q, sh2_d;
  logic                 started1_q, started1_d, started2_q, started2_d;
  logic [5:0]           cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [7:0]           good_q, good_d;
  logic [0:0]           state_q, state_d;
  logic [OUT_WIDTH-1:0] ch1_q, ch1_d, ch2_q, ch2_d;
  logic                 vld1_q, vld1_d, vld2_q, vld2_d;
  logic                 err_q, err_d;
  logic                 tick, fall1, fall2, bad_locked;

  // Field layout: exponent in sr[15:13], 10-bit signed mantissa in sr[12:3].
  function automatic logic [OUT_WIDTH-1:0] to_pcm(input logic [15:0] s);
    logic [OUT_WIDTH-1:0] m;
    m = {{(OUT_WIDTH-10){s[12]}}, s[12:3]};
    if (s[15:13] == 3'd0) return '0;
    return m << (s[15:13] - 3'd1);
  endfunction

  assign tick  = !i_phi1_NCEN_n;
  assign fall1 = tick & sh1_q & !i_SH1;
  assign fall2 = tick & sh2_q & !i_SH2;

  always_comb begin
    sr_d       = sr_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    started1_d = started1_q | fall1;
    started2_d = started2_q | fall2;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    good_d     = good_q;
    state_d    = state_q;
    ch1_d      = ch1_q;
    ch2_d      = ch2_q;
    vld1_d     = 1'b0;
    vld2_d     = 1'b0;
    err_d      = err_q;
    bad_locked = 1'b0;

    if (tick) begin
      sr_d  = {i_SO, sr_q[15:1]};
      sh1_d = i_SH1;
      sh2_d = i_SH2;
      // Counters stay idle until their strobe's first fall, then saturate.
      if (fall1)                               cnt1_d = 6'd1;
      else if (started1_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 6'd1;
      if (fall2)                               cnt2_d = 6'd1;
      else if (started2_q && cnt2_q != CNT_MAX) cnt2_d = cnt2_q + 6'd1;
    end

    if (fall1) begin
      ch1_d  = to_pcm(sr_q);
      vld1_d = 1'b1;
      if (sr_q[15:13] == 3'd0) err_d = 1'b1;
    end
    if (fall2) begin
      ch2_d  = to_pcm(sr_q);
      vld2_d = 1'b1;
      if (sr_q[15:13] == 3'd0) err_d = 1'b1;
    end
    if (fall1 && fall2) err_d = 1'b1;

    if (state_q == ST_SEARCH) begin
      if (fall1 && started1_q) begin
        if (cnt1_q == PERIOD) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 >= GOOD_MAX) state_d = ST_LOCKED;
        end else begin
          good_d = 8'd0;
        end
      end
    end else begin
      bad_locked = (fall1 && started1_q && cnt1_q != PERIOD) ||
                   (fall2 && started2_q && cnt2_q != PERIOD) ||
                   (tick && (cnt1_d == CNT_MAX || cnt2_d == CNT_MAX));
      if (bad_locked) begin
        state_d = ST_SEARCH;
        good_d  = 8'd0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      sr_q       <= '0;
      sh1_q      <= 1'b0;
      sh2_q      <= 1'b0;
      started1_q <= 1'b0;
      started2_q <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      good_q     <= '0;
      state_q    <= ST_SEARCH;
      ch1_q      <= '0;
      ch2_q      <= '0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      started1_q <= started1_d;
      started2_q <= started2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      good_q     <= good_d;
      state_q    <= state_d;
      ch1_q      <= ch1_d;
      ch2_q      <= ch2_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      err_q      <= err_d;
    end
  end

  assign o_CH1       = ch1_q;
  assign o_CH2       = ch2_q;
  assign o_CH1_VALID = vld1_q;
  assign o_CH2_VALID = vld2_q;
  assign o_LOCKED    = (state_q == ST_LOCKED);
  assign o_FRAME_ERR = err_q;

endmodule
